// File: rtl/demodulador_fsk_pkg.sv
// Shared types and helpers for the FSK demodulator: FSM encoding,
// accumulator width and the magnitude function used by the bit decision.
package demod_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } estado_t;

    // 16 samples of up to 255 each side gives +/-4080, which fits in 14 signed bits.
    localparam int ACC_W = 14;

    function automatic logic [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] neg;
        neg = -v;
        return v[ACC_W-1] ? neg : v;
    endfunction

endpackage

// File: rtl/demodulador_fsk_if.sv
// Sample-in / byte-out bundle between the sample source and the demodulator.
// Handshake: there is no backpressure. A sample is consumed on every rising
// clk edge where amostra_valida=1; sinc is only meaningful together with
// amostra_valida. byte_valido is a single-cycle strobe qualifying dado_rx and
// erro_rx, which hold their value between strobes.
interface demodulador_fsk_if #(
    parameter int W = 8
);
    logic [7:0]   amostra;
    logic         amostra_valida;
    logic         sinc;
    logic [W-1:0] dado_rx;
    logic         byte_valido;
    logic         erro_rx;
    logic         ocupado;
    logic [0:0]   estado_dbg;

    modport master (
        output amostra, amostra_valida, sinc,
        input  dado_rx, byte_valido, erro_rx, ocupado, estado_dbg
    );

    modport slave (
        input  amostra, amostra_valida, sinc,
        output dado_rx, byte_valido, erro_rx, ocupado, estado_dbg
    );
endinterface

// File: rtl/demodulador_fsk_detector_bit.sv
// Per-bit half-window detector: accumulates first-half samples minus
// second-half samples and decides the bit on the last sample of the window.
module detector_bit
    import demod_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 32,
    parameter int THRESH          = 1024,
    parameter int GUARD           = 512,
    localparam int IDX_W          = $clog2(SAMPLES_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       amostra,
    input  logic             valid,
    input  logic [IDX_W-1:0] index,
    input  logic             clear,
    output logic             bit_ok,
    output logic             bit_rx,
    output logic             ambiguo
);

    localparam logic [ACC_W-1:0] LIM_T  = ACC_W'(THRESH);
    localparam logic [ACC_W-1:0] LIM_LO = ACC_W'(THRESH - GUARD);
    localparam logic [ACC_W-1:0] LIM_HI = ACC_W'(THRESH + GUARD - 1);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] amostra_ext;
    logic        [ACC_W-1:0] mag;

    // The 128 offset appears equally in both halves, so raw samples are used.
    always_comb begin
        amostra_ext = $signed({{(ACC_W-8){1'b0}}, amostra});
        acc_base    = clear ? '0 : acc_q;
        acc_next    = index[IDX_W-1] ? (acc_base - amostra_ext) : (acc_base + amostra_ext);
        mag         = abs_acc(acc_next);
        bit_ok      = valid & (&index);
        bit_rx      = (mag < LIM_T);
        ambiguo     = (mag >= LIM_LO) && (mag <= LIM_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (valid) begin
            acc_q <= bit_ok ? '0 : acc_next;
        end
    end

endmodule

// File: rtl/demodulador_fsk.sv
// FSK demodulator top: sync-driven FSM, sample/bit counters, LSB-first
// shift register and the registered byte outputs.
module demodulador_fsk
    import demod_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 32,
    parameter int BITS_PER_BYTE   = 8,
    parameter int THRESH          = 1024,
    parameter int GUARD           = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    demodulador_fsk_if.slave bus
);

    localparam int IDX_W = $clog2(SAMPLES_PER_BIT);
    localparam int BIT_W = $clog2(BITS_PER_BYTE);

    localparam logic [0:0]       S_IDLE   = IDLE;
    localparam logic [0:0]       S_RECV   = RECV;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_BYTE - 1);

    logic [0:0]               estado_q;
    logic [IDX_W-1:0]         idx_q;
    logic [IDX_W-1:0]         idx_eff;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic [BITS_PER_BYTE-1:0] shreg_q;
    logic [BITS_PER_BYTE-1:0] shreg_next;
    logic [BITS_PER_BYTE-1:0] dado_q;
    logic                     sticky_q;
    logic                     erro_q;
    logic                     byte_valido_q;

    logic resync;
    logic det_valid;
    logic bit_ok;
    logic bit_rx;
    logic ambiguo;

    // A valid sinc always forces index 0, so it can never complete a bit.
    always_comb begin
        resync     = bus.amostra_valida & bus.sinc;
        det_valid  = bus.amostra_valida & (resync | (estado_q == S_RECV));
        idx_eff    = resync ? '0 : idx_q;
        shreg_next = {bit_rx, shreg_q[BITS_PER_BYTE-1:1]};
    end

    detector_bit #(
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
        .THRESH          (THRESH),
        .GUARD           (GUARD)
    ) u_detector (
        .clk     (clk),
        .rst_n   (rst_n),
        .amostra (bus.amostra),
        .valid   (det_valid),
        .index   (idx_eff),
        .clear   (resync),
        .bit_ok  (bit_ok),
        .bit_rx  (bit_rx),
        .ambiguo (ambiguo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q      <= S_IDLE;
            idx_q         <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            sticky_q      <= 1'b0;
            dado_q        <= '0;
            erro_q        <= 1'b0;
            byte_valido_q <= 1'b0;
        end else begin
            byte_valido_q <= 1'b0;
            if (resync) begin
                estado_q  <= S_RECV;
                idx_q     <= IDX_W'(1);
                bit_cnt_q <= '0;
                shreg_q   <= '0;
                sticky_q  <= 1'b0;
            end else if (det_valid) begin
                idx_q <= idx_q + IDX_W'(1);
                if (bit_ok) begin
                    shreg_q <= shreg_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        dado_q        <= shreg_next;
                        erro_q        <= sticky_q | ambiguo;
                        byte_valido_q <= 1'b1;
                        bit_cnt_q     <= '0;
                        sticky_q      <= 1'b0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        sticky_q  <= sticky_q | ambiguo;
                    end
                end
            end
        end
    end

    assign bus.dado_rx     = dado_q;
    assign bus.erro_rx     = erro_q;
    assign bus.byte_valido = byte_valido_q;
    assign bus.ocupado     = (estado_q == S_RECV);
    assign bus.estado_dbg  = estado_q;

endmodule

// File: tb/tb_demodulador_fsk.sv
// Directed bench for demodulador_fsk: a sine-table modulator model drives
// bytes, and each observation is checked with an immediate assertion.
module tb_demodulador_fsk;

  localparam int SPB = 32;
  localparam real PI = 3.14159265358979;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demodulador_fsk_if bus ();

  demodulador_fsk dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int nvalid;
  int nclk;
  int pulse_cnt;
  logic [7:0] cap_dado_q[$];
  logic       cap_erro_q[$];
  int         pulse_at_q[$];
  int         pulse_clk_q[$];
  bit         neg_ph = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    nvalid = 0;
    nclk = 0;
    pulse_cnt = 0;
    cap_dado_q.delete();
    cap_erro_q.delete();
    pulse_at_q.delete();
    pulse_clk_q.delete();
  endtask

  // One clock of stimulus; outputs are observed 1ns after the edge.
  task automatic drive(input logic [7:0] a, input logic v, input logic s);
    bus.amostra = a;
    bus.amostra_valida = v;
    bus.sinc = s;
    @(posedge clk);
    #1;
    nclk++;
    if (v) nvalid++;
    if (bus.byte_valido === 1'b1) begin
      pulse_cnt++;
      cap_dado_q.push_back(bus.dado_rx);
      cap_erro_q.push_back(bus.erro_rx);
      pulse_at_q.push_back(nvalid);
      pulse_clk_q.push_back(nclk);
    end
  endtask

  function automatic logic [7:0] mod_sample(input bit b, input int k, input bit neg);
    real r;
    r = b ? $sin(PI * k / SPB) : $sin(2.0 * PI * k / SPB);
    if (neg) r = -r;
    return 8'($rtoi(128.5 + 127.0 * r));
  endfunction

  // Sends up to 'limit' valid samples of byte b, LSB first. amb_bit selects a
  // bit window replaced by the 191/128 pattern (D=1008); -1 for none.
  task automatic send_byte(input logic [7:0] b, input bit with_sinc, input bit throttle,
                           input int limit, input int amb_bit);
    int sent;
    logic [7:0] s;
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < SPB; k++) begin
        if (sent == limit) return;
        if (i == amb_bit) s = (k < SPB / 2) ? 8'd191 : 8'd128;
        else s = mod_sample(b[i], k, neg_ph);
        if (throttle) drive(8'hFF, 1'b0, 1'b1);
        drive(s, 1'b1, with_sinc && (sent == 0));
        sent++;
        if (k == SPB - 1 && b[i] && i != amb_bit) neg_ph = ~neg_ph;
      end
    end
  endtask

  initial begin
    bus.amostra = '0;
    bus.amostra_valida = 1'b0;
    bus.sinc = 1'b0;
    clear_log();

    // reset held while samples and sinc toggle
    for (int i = 0; i < 6; i++) drive(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    check("rst_dado", bus.dado_rx, 8'h00);
    check("rst_valid", bus.byte_valido, 1'b0);
    check("rst_erro", bus.erro_rx, 1'b0);
    check("rst_ocupado", bus.ocupado, 1'b0);
    check("rst_estado", bus.estado_dbg, 1'b0);
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 40; i++) drive(mod_sample(1'b0, i % SPB, 1'b0), 1'b1, 1'b0);
    check("nosinc_ocupado", bus.ocupado, 1'b0);
    check("nosinc_pulses", pulse_cnt, 0);

    // golden byte 0xA5
    clear_log();
    send_byte(8'hA5, 1'b1, 1'b0, 256, -1);
    check("gold_pulses", pulse_cnt, 1);
    check("gold_ocupado", bus.ocupado, 1'b1);
    if (pulse_cnt >= 1) begin
      check("gold_at", pulse_at_q[0], 256);
      check("gold_clk", pulse_clk_q[0], 256);
      check("gold_dado", cap_dado_q[0], 8'hA5);
      check("gold_erro", cap_erro_q[0], 1'b0);
    end
    for (int i = 0; i < 5; i++) drive(8'h00, 1'b0, 1'b0);
    check("hold_dado", bus.dado_rx, 8'hA5);
    check("hold_erro", bus.erro_rx, 1'b0);
    check("hold_pulses", pulse_cnt, 1);

    // back-to-back 0x00 then 0xFF with a single sinc
    clear_log();
    send_byte(8'h00, 1'b1, 1'b0, 256, -1);
    send_byte(8'hFF, 1'b0, 1'b0, 256, -1);
    check("b2b_pulses", pulse_cnt, 2);
    if (pulse_cnt >= 2) begin
      check("b2b_at0", pulse_at_q[0], 256);
      check("b2b_at1", pulse_at_q[1], 512);
      check("b2b_dado0", cap_dado_q[0], 8'h00);
      check("b2b_dado1", cap_dado_q[1], 8'hFF);
      check("b2b_erro0", cap_erro_q[0], 1'b0);
      check("b2b_erro1", cap_erro_q[1], 1'b0);
    end

    // throttled 0x3C: invalid 0xFF (with sinc) on every other clock
    clear_log();
    send_byte(8'h3C, 1'b1, 1'b1, 256, -1);
    check("thr_pulses", pulse_cnt, 1);
    if (pulse_cnt >= 1) begin
      check("thr_clk", pulse_clk_q[0], 512);
      check("thr_dado", cap_dado_q[0], 8'h3C);
      check("thr_erro", cap_erro_q[0], 1'b0);
    end

    // resync after 100 samples of 0x12
    clear_log();
    send_byte(8'h12, 1'b1, 1'b0, 100, -1);
    send_byte(8'h81, 1'b1, 1'b0, 256, -1);
    check("rsy_pulses", pulse_cnt, 1);
    if (pulse_cnt >= 1) begin
      check("rsy_at", pulse_at_q[0], 356);
      check("rsy_dado", cap_dado_q[0], 8'h81);
    end

    // sinc lands on the final sample of 0x55
    clear_log();
    send_byte(8'h55, 1'b1, 1'b0, 255, -1);
    send_byte(8'h99, 1'b1, 1'b0, 256, -1);
    check("rsyf_pulses", pulse_cnt, 1);
    if (pulse_cnt >= 1) begin
      check("rsyf_at", pulse_at_q[0], 511);
      check("rsyf_dado", cap_dado_q[0], 8'h99);
    end

    // ambiguous bit 3 inside 0x00, then a clean byte clears the flag
    clear_log();
    send_byte(8'h00, 1'b1, 1'b0, 256, 3);
    check("amb_pulses", pulse_cnt, 1);
    if (pulse_cnt >= 1) begin
      check("amb_dado", cap_dado_q[0], 8'h08);
      check("amb_erro", cap_erro_q[0], 1'b1);
    end
    clear_log();
    send_byte(8'h00, 1'b0, 1'b0, 256, -1);
    check("clean_pulses", pulse_cnt, 1);
    if (pulse_cnt >= 1) begin
      check("clean_dado", cap_dado_q[0], 8'h00);
      check("clean_erro", cap_erro_q[0], 1'b0);
    end

    // reset mid-byte after a byte with erro set
    clear_log();
    send_byte(8'h00, 1'b1, 1'b0, 256, 5);
    send_byte(8'hC3, 1'b1, 1'b0, 100, -1);
    check("mid_ocupado", bus.ocupado, 1'b1);
    check("mid_erro_before", bus.erro_rx, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_dado", bus.dado_rx, 8'h00);
    check("mid_erro", bus.erro_rx, 1'b0);
    check("mid_valid", bus.byte_valido, 1'b0);
    check("mid_ocupado_rst", bus.ocupado, 1'b0);
    check("mid_estado", bus.estado_dbg, 1'b0);
    drive(8'h80, 1'b1, 1'b0);
    rst_n = 1'b1;
    clear_log();
    send_byte(8'hC3, 1'b0, 1'b0, 156, -1);
    check("post_pulses", pulse_cnt, 0);
    check("post_ocupado", bus.ocupado, 1'b0);
    check("post_dado", bus.dado_rx, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
